seg7_digit_scanner: RTL and testbench

//  Time-multiplexed scan controller placed directly upstream of the 7-segment digit decoder.
//  - Holds a multi-digit hex value and feeds one 4-bit nibble per scan slot to the decoder.
//  - Drives the matching active-low digit anodes, delayed one cycle to line up with the decoder's input register.
//  - Applies new values only at frame boundaries (no tearing).
//  - Supports leading-zero blanking and an anti-ghosting guard interval.

---
 rtl/seg7_digit_scanner.sv | 115 +++++++++++
 tb/tb_seg7_digit_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_scanner.sv
// Multiplexed scan controller feeding one nibble per slot to a 7-segment decoder.
// Anodes trail the nibble by one cycle to match the decoder's input register.
module seg7_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLANK_LZ     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done,
    output logic                    update_pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] TICK_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         tick_cnt;
    logic [IW-1:0]         digit_idx;
    logic [VW-1:0]         shadow;
    logic [VW-1:0]         active;
    logic                  pending;
    logic                  tick;
    logic                  boundary;
    logic [3:0]            nibble_sel;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  blank_sel;
    logic [IW-1:0]         s1_idx;
    logic                  s1_off;
    logic [NUM_DIGITS-1:0] anode_sel;

    assign tick           = (tick_cnt == TICK_MAX);
    assign boundary       = tick && (digit_idx == IDX_MAX);
    assign update_pending = pending;

    // A digit is blank when it and every more-significant nibble is zero.
    always_comb begin : blank_scan
        logic zero_above;
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (active[4*i +: 4] == 4'h0);
            if (i > 0) begin
                blank_mask[i] = (BLANK_LZ != 0) && zero_above;
            end
        end
    end

    always_comb begin
        nibble_sel = '0;
        blank_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == digit_idx) begin
                nibble_sel = active[4*i +: 4];
                blank_sel  = blank_mask[i];
            end
        end
    end

    always_comb begin
        anode_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == s1_idx) begin
                anode_sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt   <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            nibble_out <= '0;
            s1_idx     <= '0;
            s1_off     <= 1'b1;
            anode_n    <= '1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            if (tick) begin
                digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IW'(1);
            end
            frame_done <= boundary;
            // A strobe landing on the boundary bypasses the shadow entirely.
            if (boundary) begin
                pending <= 1'b0;
                if (value_valid) begin
                    active <= value_in;
                end else if (pending) begin
                    active <= shadow;
                end
            end else if (value_valid) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end
            nibble_out <= nibble_sel;
            s1_idx     <= digit_idx;
            s1_off     <= (tick_cnt < GUARD_END) || blank_sel;
            anode_n    <= s1_off ? '1 : anode_sel;
        end
    end

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Randomized and directed bench for seg7_digit_scanner against a
// cycle-number based reference model, with blanking on and off.
module tb_seg7_digit_scanner;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int FR    = ND * DIV;
    localparam int HMAX  = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic        value_valid = 1'b0;

    logic [3:0] nib_a, nib_b;
    logic [3:0] an_a, an_b;
    logic       fd_a, fd_b;
    logic       up_a, up_b;

    int checks = 0;
    int errors = 0;

    // Model: m = edges since reset released, act[k] = displayed value after edge k.
    int          m = 0;
    logic [15:0] act [0:HMAX-1];
    logic [15:0] mdl_shadow = '0;
    logic [15:0] mdl_cur = '0;
    bit          mdl_pend = 1'b0;
    logic [3:0]  prev_a = '0;
    logic [3:0]  prev_b = '0;

    seg7_digit_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV),
        .GUARD_CYCLES(GUARD), .BLANK_LZ(1)
    ) dut_a (
        .clock(clock), .reset(reset),
        .value_in(value_in), .value_valid(value_valid),
        .nibble_out(nib_a), .anode_n(an_a),
        .frame_done(fd_a), .update_pending(up_a)
    );

    seg7_digit_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV),
        .GUARD_CYCLES(GUARD), .BLANK_LZ(0)
    ) dut_b (
        .clock(clock), .reset(reset),
        .value_in(value_in), .value_valid(value_valid),
        .nibble_out(nib_b), .anode_n(an_b),
        .frame_done(fd_b), .update_pending(up_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] digit_of(logic [15:0] v, int d);
        return 4'((v >> (4 * d)) & 16'hF);
    endfunction

    function automatic logic [3:0] exp_anode(int mm, bit blz);
        int d, pos;
        logic [15:0] v;
        if (mm < 2) return 4'hF;
        d   = ((mm - 2) / DIV) % ND;
        pos = (mm - 2) % DIV;
        v   = act[mm - 2];
        if (pos < GUARD) return 4'hF;
        if (blz && d > 0 && (v >> (4 * d)) == 16'h0) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    // Decoder model: its register holds the previous nibble while anodes are live.
    task automatic score(input string tag, input logic [3:0] an,
                         input logic [3:0] prev);
        int d;
        if (an != 4'hF) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (!an[i]) d = i;
            chk({tag, "_onehot"}, 32'($countones(~an)), 32'd1);
            chk({tag, "_align"}, 32'(prev), 32'(digit_of(act[m - 2], d)));
        end
    endtask

    task automatic check_all();
        logic [3:0] en;
        bit fd;
        en = digit_of(act[m - 1], ((m - 1) / DIV) % ND);
        fd = (m % FR == 0);
        chk("nibble_a", 32'(nib_a), 32'(en));
        chk("nibble_b", 32'(nib_b), 32'(en));
        chk("anode_a", 32'(an_a), 32'(exp_anode(m, 1'b1)));
        chk("anode_b", 32'(an_b), 32'(exp_anode(m, 1'b0)));
        chk("frame_done_a", 32'(fd_a), 32'(fd));
        chk("frame_done_b", 32'(fd_b), 32'(fd));
        chk("pending_a", 32'(up_a), 32'(mdl_pend));
        chk("pending_b", 32'(up_b), 32'(mdl_pend));
        score("dec_a", an_a, prev_a);
        score("dec_b", an_b, prev_b);
        prev_a = nib_a;
        prev_b = nib_b;
    endtask

    task automatic step(input bit v, input logic [15:0] val);
        bit bnd;
        value_valid = v;
        value_in    = val;
        @(posedge clock);
        #1;
        m++;
        if (m >= HMAX) begin
            $display("FAIL history: model history exhausted at %0d", m);
            $fatal(1);
        end
        bnd = (m % FR == 0);
        if (bnd) begin
            if (v) mdl_cur = val;
            else if (mdl_pend) mdl_cur = mdl_shadow;
            mdl_pend = 1'b0;
        end else if (v) begin
            mdl_shadow = val;
            mdl_pend   = 1'b1;
        end
        act[m] = mdl_cur;
        check_all();
        value_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    // Advance so the next step lands on the given frame phase.
    task automatic to_phase(input int ph);
        while (((m + 1) % FR) != ph) step(1'b0, 16'h0);
    endtask

    task automatic do_reset(input int cycles);
        reset       = 1'b1;
        value_valid = 1'b1;
        value_in    = 16'($urandom);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            chk("rst_nibble", 32'({nib_a, nib_b}), 32'h00);
            chk("rst_anode", 32'({an_a, an_b}), 32'hFF);
            chk("rst_frame", 32'({fd_a, fd_b}), 32'h0);
            chk("rst_pending", 32'({up_a, up_b}), 32'h0);
        end
        reset       = 1'b0;
        value_valid = 1'b0;
        m           = 0;
        act[0]      = '0;
        mdl_shadow  = '0;
        mdl_cur     = '0;
        mdl_pend    = 1'b0;
        prev_a      = '0;
        prev_b      = '0;
    endtask

    initial begin
        logic [15:0] rv;
        do_reset(3);
        run(7);
        do_reset(1);

        to_phase(5);
        step(1'b1, 16'h1234);
        chk("load_pending", 32'(up_a), 32'd1);
        run(2 * FR);

        to_phase(6);
        step(1'b1, 16'h0045);
        run(2 * FR);
        to_phase(6);
        step(1'b1, 16'h0000);
        run(2 * FR);

        to_phase(2);
        step(1'b1, 16'hAAAA);
        run(3);
        step(1'b1, 16'h5555);
        run(2 * FR);

        to_phase(4);
        step(1'b1, 16'h1111);
        to_phase(0);
        step(1'b1, 16'hBEEF);
        chk("beef_pending", 32'(up_a), 32'd0);
        run(FR + 2);

        for (int n = 0; n < 16; n++) begin
            to_phase(3);
            step(1'b1, 16'(n));
            run(FR + 4);
        end

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
                step($urandom_range(0, 7) == 0, rv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
